// File: rtl/game_ctrl_if.sv
// rtl/game_ctrl_if.sv - game_ctrl player inputs and game-flow outputs
interface game_ctrl_if;
    logic       start_btn;
    logic       hit_wall;
    logic       hit_body;
    logic [1:0] game_status;
    logic       step_tick;
    logic       flash_on;

    // Controller side: consumes button/collision, owns status, tick and blink
    modport master (
        input  start_btn,
        input  hit_wall,
        input  hit_body,
        output game_status,
        output step_tick,
        output flash_on
    );

    // Surrounding logic side: drives button/collision, observes game flow
    modport slave (
        output start_btn,
        output hit_wall,
        output hit_body,
        input  game_status,
        input  step_tick,
        input  flash_on
    );
endinterface

// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - snake game-flow FSM with step tick and death-flash blink
module game_ctrl #(
    parameter int INIT_CYCLES  = 4,
    parameter int STEP_CYCLES  = 25_000_000,
    parameter int FLASH_CYCLES = 300_000_000,
    parameter int FLASH_TOGGLE = 25_000_000
) (
    input  logic        clock,
    input  logic        reset,
    game_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        LAUNCHING    = 2'b00,
        PLAYING      = 2'b01,
        DIE_FLASHING = 2'b10,
        INITIALIZING = 2'b11
    } state_t;

    localparam logic [31:0] INIT_LAST  = 32'(INIT_CYCLES - 1);
    localparam logic [31:0] STEP_LAST  = 32'(STEP_CYCLES - 1);
    localparam logic [31:0] FLASH_LAST = 32'(FLASH_CYCLES - 1);
    localparam logic [31:0] TGL_LAST   = 32'(FLASH_TOGGLE - 1);

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] tgl_cnt, tgl_cnt_nxt;
    logic        step_tick_q, step_tick_nxt;
    logic        flash_q, flash_nxt;
    logic        start_d;
    // A press only counts once the button has been seen released after reset,
    // so a button held through reset release cannot launch a game.
    logic        armed;
    logic        start_rise;
    logic        die;

    assign start_rise = bus.start_btn & ~start_d & armed;
    assign die        = bus.hit_wall | bus.hit_body;

    assign bus.game_status = state;
    assign bus.step_tick   = step_tick_q;
    assign bus.flash_on    = flash_q;

    // State, shared counter, blink sub-counter and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= LAUNCHING;
            cnt         <= '0;
            tgl_cnt     <= '0;
            step_tick_q <= 1'b0;
            flash_q     <= 1'b0;
            start_d     <= 1'b0;
            armed       <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            tgl_cnt     <= tgl_cnt_nxt;
            step_tick_q <= step_tick_nxt;
            flash_q     <= flash_nxt;
            start_d     <= bus.start_btn;
            armed       <= armed | ~bus.start_btn;
        end
    end

    // Next state plus next values of the counters and registered outputs
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + 32'd1;
        tgl_cnt_nxt   = '0;
        step_tick_nxt = 1'b0;
        flash_nxt     = 1'b0;
        case (state)
            LAUNCHING: begin
                cnt_nxt = '0;
                if (start_rise) begin
                    state_nxt = INITIALIZING;
                end
            end
            INITIALIZING: begin
                if (cnt == INIT_LAST) begin
                    state_nxt = PLAYING;
                    cnt_nxt   = '0;
                end
            end
            PLAYING: begin
                // Death wins over the step that would have been emitted
                if (die) begin
                    state_nxt = DIE_FLASHING;
                    cnt_nxt   = '0;
                    flash_nxt = 1'b1;
                end else if (cnt == STEP_LAST) begin
                    cnt_nxt       = '0;
                    step_tick_nxt = 1'b1;
                end
            end
            DIE_FLASHING: begin
                if (cnt == FLASH_LAST) begin
                    state_nxt = LAUNCHING;
                    cnt_nxt   = '0;
                end else if (tgl_cnt == TGL_LAST) begin
                    flash_nxt = ~flash_q;
                end else begin
                    tgl_cnt_nxt = tgl_cnt + 32'd1;
                    flash_nxt   = flash_q;
                end
            end
            default: begin
                state_nxt = LAUNCHING;
                cnt_nxt   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - randomized and directed bench for game_ctrl
module tb_game_ctrl;
    localparam int INIT  = 3;
    localparam int STEP  = 4;
    localparam int FLASH = 8;
    localparam int TOG   = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    game_ctrl_if bus ();

    game_ctrl #(
        .INIT_CYCLES (INIT),
        .STEP_CYCLES (STEP),
        .FLASH_CYCLES(FLASH),
        .FLASH_TOGGLE(TOG)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference: status code plus 1-based age within the current status
    int m_st;
    int m_age;
    bit m_prev_btn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_st       = 0;
        m_age      = 1;
        m_prev_btn = 1'b1;   // a press needs a released sample first
    endfunction

    function automatic void model_step(input bit btn, input bit die);
        bit rise;
        rise       = btn && !m_prev_btn;
        m_prev_btn = btn;
        case (m_st)
            0: if (rise) begin m_st = 3; m_age = 1; end else m_age++;
            3: if (m_age == INIT) begin m_st = 1; m_age = 1; end else m_age++;
            1: if (die) begin m_st = 2; m_age = 1; end else m_age++;
            default: if (m_age == FLASH) begin m_st = 0; m_age = 1; end else m_age++;
        endcase
    endfunction

    function automatic int exp_tick();
        return (m_st == 1 && m_age > 1 && (m_age - 1) % STEP == 0) ? 1 : 0;
    endfunction

    function automatic int exp_flash();
        return (m_st == 2 && ((m_age - 1) / TOG) % 2 == 0) ? 1 : 0;
    endfunction

    task automatic check_model(input string tag);
        check({tag, " status"}, bus.game_status, m_st);
        check({tag, " tick"},   bus.step_tick,   exp_tick());
        check({tag, " flash"},  bus.flash_on,    exp_flash());
    endtask

    task automatic cycle();
        bit btn, die;
        btn = bus.start_btn;
        die = bus.hit_wall | bus.hit_body;
        @(posedge clock);
        model_step(btn, die);
        #1;
        check_model("cyc");
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_model("rst");
        @(posedge clock);
        #1;
        check_model("rst_hold");
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    task automatic do_loop(input int play_len, output int init_len, output int flash_len,
                           output int ticks, output logic [7:0] pat);
        int n;
        bus.start_btn = 1'b0;
        bus.hit_wall  = 1'b1;
        cycle();
        bus.hit_wall = 1'b0;
        check("launch_ignores_wall", bus.game_status, 0);
        bus.start_btn = 1'b1;
        cycle();
        check("start_to_init", bus.game_status, 3);
        init_len = 0;
        while (bus.game_status == 2'b11 && init_len < 50) begin
            init_len++;
            bus.hit_wall  = 1'b1;
            bus.start_btn = ~bus.start_btn;
            cycle();
        end
        bus.hit_wall  = 1'b0;
        bus.start_btn = 1'b0;
        check("enter_play", bus.game_status, 1);
        ticks = 0;
        n = 1;
        while (bus.game_status == 2'b01 && n < play_len) begin
            bus.start_btn = n[1];
            cycle();
            n++;
            if (bus.step_tick) ticks++;
        end
        check("play_len", n, play_len);
        bus.start_btn = 1'b0;
        bus.hit_body  = 1'b1;
        cycle();
        bus.hit_body = 1'b0;
        check("die_no_tick", bus.step_tick, 0);
        check("die_status", bus.game_status, 2);
        check("die_flash", bus.flash_on, 1);
        flash_len = 0;
        pat = '0;
        while (bus.game_status == 2'b10 && flash_len < 50) begin
            pat = {pat[6:0], bus.flash_on};
            flash_len++;
            bus.start_btn = flash_len[0];
            cycle();
        end
        bus.start_btn = 1'b0;
        check("after_flash_status", bus.game_status, 0);
        check("after_flash_flash", bus.flash_on, 0);
    endtask

    initial begin
        int il1, fl1, tk1, il2, fl2, tk2;
        logic [7:0] p1, p2;
        bus.start_btn = 1'b1;
        bus.hit_wall  = 1'b0;
        bus.hit_body  = 1'b0;
        model_reset();

        // Button held through reset release must not launch
        hold_reset();
        for (int i = 0; i < 3; i++) cycle();
        check("held_btn_no_start", bus.game_status, 0);

        // Two full loops; 20 playing cycles then die on a tick-producing count
        do_loop(20, il1, fl1, tk1, p1);
        check("init_len1", il1, INIT);
        check("flash_len1", fl1, FLASH);
        check("ticks1", tk1, 4);
        check("flash_pat1", p1, 8'b1100_1100);
        do_loop(8, il2, fl2, tk2, p2);
        check("init_len2", il2, il1);
        check("flash_len2", fl2, fl1);
        check("ticks2", tk2, 1);
        check("flash_pat2", p2, p1);

        // Async reset during flash cycle 4
        bus.start_btn = 1'b0;
        cycle();
        bus.start_btn = 1'b1;
        cycle();
        bus.start_btn = 1'b0;
        for (int i = 0; i < INIT + 2 && bus.game_status != 2'b01; i++) cycle();
        bus.hit_wall = 1'b1;
        cycle();
        bus.hit_wall = 1'b0;
        check("flash_entry", bus.game_status, 2);
        for (int i = 0; i < 3; i++) cycle();
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_status", bus.game_status, 0);
        check("async_rst_flash", bus.flash_on, 0);
        check("async_rst_tick", bus.step_tick, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;

        // Randomized run, occasional mid-cycle reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) bus.start_btn = ~bus.start_btn;
            bus.hit_wall = ($urandom_range(0, 15) == 0);
            bus.hit_body = ($urandom_range(0, 15) == 0);
            cycle();
            if ($urandom_range(0, 399) == 0) begin
                #2;
                reset = 1'b0;
                model_reset();
                #1;
                check_model("rand_rst");
                @(negedge clock);
                reset = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
